tune_sequencer: RTL and testbench



---
 rtl/tune_sequencer_pkg.sv | 43 ++++
 rtl/note_fifo.sv | 70 +++++++
 rtl/tune_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tune_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tune_sequencer_pkg.sv
// Shared state encoding, register bit map and timing constants for the
// note sequencer and its FIFO.
package tune_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    PLAYING,
    GAP
  } seq_state_t;

  localparam int STAT_PLAYING_BIT  = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_EMPTY_BIT    = 2;
  localparam int STAT_OVERFLOW_BIT = 3;
  localparam int STAT_COUNT_LSB    = 8;
  localparam int STAT_COUNT_W      = 8;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  // Cycles WAIT_START tolerates without tone_busy before giving up on the note.
  localparam int WAIT_START_TIMEOUT = 4;

  function automatic logic [31:0] pack_status(
    input logic [STAT_COUNT_W-1:0] count,
    input logic                    overflow,
    input logic                    empty,
    input logic                    full,
    input logic                    playing
  );
    logic [31:0] w_word;
    w_word = '0;
    w_word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    w_word[STAT_OVERFLOW_BIT]              = overflow;
    w_word[STAT_EMPTY_BIT]                 = empty;
    w_word[STAT_FULL_BIT]                  = full;
    w_word[STAT_PLAYING_BIT]               = playing;
    return w_word;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO holding packed notes; flush overrides push and pop.
module note_fifo
  import tune_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Fullness is judged before any same-cycle pop, so a push into a full
  // FIFO is dropped even while the head is leaving.
  assign w_push_ok = push & ~full & ~flush;
  assign w_pop_ok  = pop & ~empty & ~flush;

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/tune_sequencer.sv
// Bus-mapped note sequencer: queues packed notes and plays them one at a time
// on the tone generator with a fixed silent gap between notes.
module tune_sequencer
  import tune_sequencer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        note_cs,
  input  logic        control_cs,
  input  logic        status_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic [15:0] tone_period,
  output logic [15:0] tone_duration,
  output logic        tone_start,
  output logic        tone_stop,
  input  logic        tone_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(WAIT_START_TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  seq_state_t    r_state;
  logic          r_run;
  logic          r_overflow;
  logic [15:0]   r_tone_period;
  logic [15:0]   r_tone_duration;
  logic          r_tone_start;
  logic          r_tone_stop;
  logic [WW-1:0] r_wait_cnt;
  logic [GW-1:0] r_gap_cnt;

  logic          w_note_push;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_status_rd;
  logic          w_pop;
  logic [31:0]   w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_playing;

  assign w_note_push = write & note_cs;
  assign w_ctrl_wr   = write & control_cs;
  assign w_flush     = w_ctrl_wr & data_in[CTRL_FLUSH_BIT];
  assign w_status_rd = read & status_cs;
  assign w_pop       = (r_state == ISSUE);
  assign w_playing   = (r_state != IDLE);

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_note_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (w_note_push),
    .pop     (w_pop),
    .flush   (w_flush),
    .data_in (data_in),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_run <= data_in[CTRL_RUN_BIT];
      end
      if (w_flush) begin
        r_overflow <= 1'b0;
      end else if (w_note_push && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Flush preempts every state; tone_stop only fires if a note was in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_tone_period   <= '0;
      r_tone_duration <= '0;
      r_tone_start    <= 1'b0;
      r_tone_stop     <= 1'b0;
      r_wait_cnt      <= '0;
      r_gap_cnt       <= '0;
    end else begin
      r_tone_start <= 1'b0;
      r_tone_stop  <= 1'b0;
      if (w_flush) begin
        r_state     <= IDLE;
        r_tone_stop <= (r_state != IDLE);
      end else begin
        case (r_state)
          IDLE: begin
            if (r_run && !w_empty) begin
              r_state <= ISSUE;
            end
          end
          ISSUE: begin
            r_tone_period   <= w_head[31:16];
            r_tone_duration <= w_head[15:0];
            r_tone_start    <= 1'b1;
            r_wait_cnt      <= '0;
            r_state         <= WAIT_START;
          end
          WAIT_START: begin
            if (tone_busy) begin
              r_state <= PLAYING;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          PLAYING: begin
            if (!tone_busy) begin
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end
          end
          GAP: begin
            if ((GAP_CYCLES == 0) || (r_gap_cnt == GAP_LAST)) begin
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_out_valid = w_status_rd;
  assign data_out       = w_status_rd ?
                          pack_status(STAT_COUNT_W'(w_count), r_overflow, w_empty, w_full, w_playing) :
                          32'h0;

  assign tone_period   = r_tone_period;
  assign tone_duration = r_tone_duration;
  assign tone_start    = r_tone_start;
  assign tone_stop     = r_tone_stop;

endmodule

// File: tb/tb_tune_sequencer.sv
// Randomized scoreboard bench for tune_sequencer with a tone generator model
// and a note-level reference model of queueing and inter-note timing.
module tb_tune_sequencer;

  localparam int DEPTH = 16;
  localparam int GAP   = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        note_cs = 1'b0;
  logic        control_cs = 1'b0;
  logic        status_cs = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [15:0] tone_period;
  logic [15:0] tone_duration;
  logic        tone_start;
  logic        tone_stop;
  logic        tone_busy;

  always #5 clock = ~clock;

  tune_sequencer #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .write          (write),
    .note_cs        (note_cs),
    .control_cs     (control_cs),
    .status_cs      (status_cs),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .tone_period    (tone_period),
    .tone_duration  (tone_duration),
    .tone_start     (tone_start),
    .tone_stop      (tone_stop),
    .tone_busy      (tone_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Tone generator: sounds for 'duration' cycles after the cycle it sees tone_start.
  int busy_rem;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tone_busy <= 1'b0;
      busy_rem  <= 0;
    end else if (tone_stop) begin
      tone_busy <= 1'b0;
    end else if (tone_start) begin
      if (tone_duration != 16'h0) begin
        tone_busy <= 1'b1;
        busy_rem  <= int'(tone_duration) - 1;
      end
    end else if (tone_busy) begin
      if (busy_rem == 0) tone_busy <= 1'b0;
      else busy_rem <= busy_rem - 1;
    end
  end

  // Reference model: queued notes with the cycle they became visible, when the
  // sequencer is next free, and when run was last enabled.
  typedef struct {
    logic [15:0] period;
    logic [15:0] duration;
    int          avail;
  } note_t;

  note_t       model_q[$];
  logic [31:0] exp_stat_q[$];
  int          exp_stop_q[$];
  bit          model_run = 1'b0;
  bit          model_ovf = 1'b0;
  int          idle_from = 0;
  int          run_from = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: cycle %0d %s", name, cyc, what);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clock) begin
    note_t n;
    int    exp_cyc;
    int    exp_stop;
    if (!reset) begin
      if (tone_start) begin
        if (model_q.size() == 0 || !model_run) begin
          fail_event("unexpected_start", "got tone_start, expected none");
        end else begin
          n = model_q.pop_front();
          exp_cyc = max3(idle_from, n.avail, run_from) + 2;
          $display("start cycle=%0d period=%04h duration=%04h", cyc, tone_period, tone_duration);
          check("start_cycle", cyc, exp_cyc);
          check("period", {16'h0, tone_period}, {16'h0, n.period});
          check("duration", {16'h0, tone_duration}, {16'h0, n.duration});
          check("stop_with_start", {31'h0, tone_stop}, 32'h0);
          if (n.duration == 16'h0) idle_from = cyc + 4 + GAP;
          else idle_from = cyc + int'(n.duration) + GAP + 2;
        end
      end
      if (tone_stop) begin
        $display("stop cycle=%0d", cyc);
        if (exp_stop_q.size() == 0) fail_event("unexpected_stop", "got tone_stop, expected none");
        else begin
          exp_stop = exp_stop_q.pop_front();
          check("stop_cycle", cyc, exp_stop);
        end
      end
      if (data_out_valid) begin
        $display("status cycle=%0d data=%08h", cyc, data_out);
        if (exp_stat_q.size() == 0) fail_event("unexpected_status", "got data_out_valid, expected none");
        else check("status", data_out, exp_stat_q.pop_front());
      end
    end
  end

  task automatic push_note(input logic [15:0] p, input logic [15:0] d);
    note_t n;
    @(posedge clock); #1;
    write = 1'b1; note_cs = 1'b1; data_in = {p, d};
    @(posedge clock); #1;
    if (model_q.size() < DEPTH) begin
      n.period = p; n.duration = d; n.avail = cyc;
      model_q.push_back(n);
    end else begin
      model_ovf = 1'b1;
    end
    write = 1'b0; note_cs = 1'b0; data_in = 32'h0;
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    int f;
    @(posedge clock); #1;
    write = 1'b1; control_cs = 1'b1; data_in = v;
    @(posedge clock); #1;
    f = cyc;
    if (v[1]) begin
      if (f - 1 < idle_from) begin
        exp_stop_q.push_back(f);
        idle_from = f;
      end
      model_q.delete();
      model_ovf = 1'b0;
    end
    if (v[0] && !model_run) run_from = f;
    model_run = v[0];
    write = 1'b0; control_cs = 1'b0; data_in = 32'h0;
  endtask

  // Only called where no note is about to be issued, so the model state is exact.
  task automatic read_status();
    int cnt;
    @(posedge clock); #1;
    cnt = model_q.size();
    exp_stat_q.push_back(32'((cnt << 8) + (model_ovf ? 8 : 0) + ((cnt == 0) ? 4 : 0)
                             + ((cnt == DEPTH) ? 2 : 0) + ((cyc < idle_from) ? 1 : 0)));
    read = 1'b1; status_cs = 1'b1;
    @(posedge clock); #1;
    read = 1'b0; status_cs = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_q.delete();
    model_run = 1'b0;
    model_ovf = 1'b0;
    idle_from = cyc;
    run_from  = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((model_q.size() != 0 || cyc < idle_from) && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (model_q.size() != 0 || cyc < idle_from) fail_event("drain_timeout", "notes still pending after budget");
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (!tone_busy && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (!tone_busy) fail_event("busy_timeout", "tone_busy never rose");
  endtask

  task automatic check_tone_idle();
    check("rst_period", {16'h0, tone_period}, 32'h0);
    check("rst_duration", {16'h0, tone_duration}, 32'h0);
    check("rst_start_stop", {30'h0, tone_start, tone_stop}, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", {31'h0, data_out_valid}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_tone_idle();
    read_status();

    // Single note with run set first.
    write_ctrl(32'h1);
    push_note(16'h0100, 16'h0010);
    drain(2000);
    read_status();

    // Overfill while paused, then flush with run set.
    write_ctrl(32'h0);
    for (int i = 0; i < 17; i++) push_note(16'($urandom), 16'($urandom_range(0, 12)));
    read_status();
    write_ctrl(32'h3);
    read_status();
    repeat (10) @(posedge clock);

    // Three queued notes released together.
    write_ctrl(32'h0);
    for (int i = 0; i < 3; i++) push_note(16'($urandom), 16'($urandom_range(1, 20)));
    write_ctrl(32'h1);
    drain(3000);

    // Flush while a long note is sounding.
    push_note(16'h1234, 16'd200);
    wait_busy(50);
    read_status();
    write_ctrl(32'h3);
    read_status();

    // Zero-duration note never raises busy; the next note must still follow.
    push_note(16'hBEEF, 16'h0000);
    push_note(16'hCAFE, 16'h0005);
    drain(3000);
    read_status();

    // Random pushes while running, enough to overrun the FIFO occasionally.
    for (int i = 0; i < 22; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clock);
      push_note(16'($urandom), 16'($urandom_range(0, 12)));
    end
    drain(20000);
    read_status();

    // Reset in the middle of a note: no tone_stop, everything back to idle.
    push_note(16'h0F0F, 16'd100);
    wait_busy(50);
    do_reset();
    repeat (2) @(posedge clock);
    #1;
    check_tone_idle();
    read_status();
    repeat (10) @(posedge clock);
    #1;

    if (exp_stat_q.size() != 0) fail_event("status_pending", "status reads never presented");
    if (exp_stop_q.size() != 0) fail_event("stop_pending", "expected tone_stop never seen");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
